branch_predictor_gshare: RTL and testbench

- Parametrised next-generation branch predictor for the pipelined RISC-V core.
- Predicts in Fetch and trains in Execute.
- Combines a global history register (GHR), a table of saturating pattern counters indexed bimodally or by gshare hash, and a tagged, valid-qualified branch target buffer (BTB).
- Replaces the fixed 2-bit / untagged predictor. Adds configurable table depth, history length, counter width and index mode.

---
 rtl/branch_predictor_gshare_pkg.sv | 28 ++
 rtl/branch_predictor_gshare_if.sv | 25 ++
 rtl/branch_predictor_gshare_btb.sv | 85 ++++++++
 rtl/branch_predictor_gshare.sv | 88 ++++++++
 tb/tb_branch_predictor_gshare.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_gshare_pkg.sv
// Shared definitions for the gshare branch predictor.
//   - index-mode constants
//   - ctr_init   : weakly-not-taken reset value for a counter of a given width
//   - sat_update : one saturating step of a pattern counter
// Counters are carried in a 4-bit container (widest legal counter) and
// sliced down to the configured width by the user.
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    typedef logic [3:0] bp_ctr_t;

    function automatic bp_ctr_t ctr_init(input int ctr_bits);
        return bp_ctr_t'((1 << (ctr_bits - 1)) - 1);
    endfunction

    function automatic bp_ctr_t sat_update(input bp_ctr_t ctr, input logic taken,
                                           input int ctr_bits);
        bp_ctr_t max_v;
        max_v = bp_ctr_t'((1 << ctr_bits) - 1);
        if (taken) begin
            return (ctr == max_v) ? ctr : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Fetch/Execute interface of the branch predictor.
//   master : core side, drives the Execute training fields and PCF,
//            receives the prediction.
//   slave  : predictor side.
interface branch_predictor_gshare_if;
    logic        StallE;
    logic [31:0] PCF;
    logic [31:0] PCE;
    logic [31:0] PCTargetE;
    logic        PCSrcResE;
    logic        TargetMatchE;
    logic        BranchOpEb0;
    logic        PCSrcPredF;
    logic [31:0] PredPCTargetF;

    modport master (
        output StallE, PCF, PCE, PCTargetE, PCSrcResE, TargetMatchE, BranchOpEb0,
        input  PCSrcPredF, PredPCTargetF
    );

    modport slave (
        input  StallE, PCF, PCE, PCTargetE, PCSrcResE, TargetMatchE, BranchOpEb0,
        output PCSrcPredF, PredPCTargetF
    );
endinterface

// File: rtl/branch_predictor_gshare_btb.sv
// Tagged, valid-qualified branch target buffer.
// Ports:
//   clk, reset           : clock, async active-high clear of all entries
//   rd_pc  -> rd_hit, rd_target : Fetch lookup (combinational)
//   chk_pc -> chk_hit           : Execute lookup, used to decide on a write
//   wr_en, wr_pc, wr_target     : synchronous fill of entry pcidx(wr_pc)
// With TAG_BITS = 0 a one-bit tag held at zero is kept so that every valid
// entry compares equal.
module bp_btb
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 8,
    parameter int TAG_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output logic [31:0] rd_target,
    input  logic [31:0] chk_pc,
    output logic        chk_hit,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = (TAG_BITS > 0) ? TAG_BITS : 1;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [31:0]       target_d [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx, chk_idx, wr_idx;
    logic [TAG_W-1:0]    rd_tag, chk_tag, wr_tag;

    assign rd_idx  = rd_pc[IDX_BITS+1:2];
    assign chk_idx = chk_pc[IDX_BITS+1:2];
    assign wr_idx  = wr_pc[IDX_BITS+1:2];

    if (TAG_BITS > 0) begin : g_tag
        assign rd_tag  = rd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        assign chk_tag = chk_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        assign wr_tag  = wr_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    end else begin : g_notag
        assign rd_tag  = '0;
        assign chk_tag = '0;
        assign wr_tag  = '0;
    end

    // PC bits outside the index and tag fields play no part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc, chk_pc, wr_pc};

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_target = target_q[rd_idx];
    assign chk_hit   = valid_q[chk_idx] && (tag_q[chk_idx] == chk_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end
endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare / bimodal branch predictor.
// Ports:
//   clk, reset : core clock, async active-high reset
//   bp         : slave side of branch_predictor_gshare_if
//                (Fetch PC in, prediction out; Execute resolution in)
// Prediction is combinational from the pre-edge tables; training happens on
// the rising edge when a conditional branch sits unstalled in Execute. The
// pattern counters and the global history live here, targets in bp_btb.
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 4,
    parameter int MODE     = BP_MODE_GSHARE
) (
    input logic                         clk,
    input logic                         reset,
    branch_predictor_gshare_if.slave    bp
);
    localparam int      ENTRIES  = 1 << IDX_BITS;
    localparam bp_ctr_t CTR_INIT = ctr_init(CTR_BITS);

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic [IDX_BITS-1:0] pcidx_f, pcidx_e, ctridx_f, ctridx_e;
    logic                train, btb_we;
    logic                rd_hit, chk_hit;
    logic [31:0]         rd_target;
    bp_ctr_t             ctr_upd;

    assign pcidx_f = bp.PCF[IDX_BITS+1:2];
    assign pcidx_e = bp.PCE[IDX_BITS+1:2];

    // Both ports hash with the current (pre-update) history.
    assign ctridx_f = (MODE == BP_MODE_GSHARE) ? (pcidx_f ^ IDX_BITS'(ghr_q)) : pcidx_f;
    assign ctridx_e = (MODE == BP_MODE_GSHARE) ? (pcidx_e ^ IDX_BITS'(ghr_q)) : pcidx_e;

    assign train = bp.BranchOpEb0 & ~bp.StallE;

    // Refill on a taken branch unless the buffer already held the right target.
    assign btb_we = train & bp.PCSrcResE & (~chk_hit | ~bp.TargetMatchE);

    always_comb begin
        ctr_d   = ctr_q;
        ghr_d   = ghr_q;
        ctr_upd = sat_update(bp_ctr_t'(ctr_q[ctridx_e]), bp.PCSrcResE, CTR_BITS);
        if (train) begin
            ctr_d[ctridx_e] = ctr_upd[CTR_BITS-1:0];
            // Shift form also covers a one-bit history.
            ghr_d = (ghr_q << 1) | GHR_BITS'(bp.PCSrcResE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT[CTR_BITS-1:0];
            end
        end else begin
            ghr_q <= ghr_d;
            ctr_q <= ctr_d;
        end
    end

    bp_btb #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (bp.PCF),
        .rd_hit    (rd_hit),
        .rd_target (rd_target),
        .chk_pc    (bp.PCE),
        .chk_hit   (chk_hit),
        .wr_en     (btb_we),
        .wr_pc     (bp.PCE),
        .wr_target (bp.PCTargetE)
    );

    assign bp.PCSrcPredF    = rd_hit & ctr_q[ctridx_f][CTR_BITS-1];
    assign bp.PredPCTargetF = rd_hit ? rd_target : 32'h0;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Four predictor configurations driven with the same stimulus:
//   k0 defaults (gshare, GHR 8, 2-bit), k1 bimodal 2-bit,
//   k2 gshare with 2-bit history, k3 bimodal 3-bit counters, untagged, GHR 1.
module tb_branch_predictor_gshare;
    localparam int NK = 4;
    localparam int C_IDX  [NK] = '{8, 8, 8, 8};
    localparam int C_GHR  [NK] = '{8, 8, 2, 1};
    localparam int C_CTR  [NK] = '{2, 2, 2, 3};
    localparam int C_TAG  [NK] = '{4, 4, 4, 0};
    localparam int C_MODE [NK] = '{1, 0, 1, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br, taken, tm;
    logic [31:0] pcf, pce, tgt;

    logic        dut_pred [NK];
    logic [31:0] dut_tgt  [NK];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        branch_predictor_gshare_if bpi ();
        assign bpi.StallE       = stall;
        assign bpi.PCF          = pcf;
        assign bpi.PCE          = pce;
        assign bpi.PCTargetE    = tgt;
        assign bpi.PCSrcResE    = taken;
        assign bpi.TargetMatchE = tm;
        assign bpi.BranchOpEb0  = br;
        assign dut_pred[g]      = bpi.PCSrcPredF;
        assign dut_tgt[g]       = bpi.PredPCTargetF;

        branch_predictor_gshare #(
            .IDX_BITS (C_IDX[g]),
            .GHR_BITS (C_GHR[g]),
            .CTR_BITS (C_CTR[g]),
            .TAG_BITS (C_TAG[g]),
            .MODE     (C_MODE[g])
        ) dut (
            .clk   (clk),
            .reset (rst),
            .bp    (bpi)
        );
    end

    // ---------------- behavioural model ----------------
    int          m_ctr [NK][256];
    bit          m_v   [NK][256];
    int          m_tag [NK][256];
    logic [31:0] m_tgt [NK][256];
    int          m_ghr [NK];

    function automatic int pidx(int k, logic [31:0] pc);
        return int'(pc[31:2]) & ((1 << C_IDX[k]) - 1);
    endfunction

    function automatic int ptag(int k, logic [31:0] pc);
        return int'(pc >> (C_IDX[k] + 2)) & ((1 << C_TAG[k]) - 1);
    endfunction

    function automatic int cidx(int k, logic [31:0] pc, int ghr);
        return (C_MODE[k] == 1) ? (pidx(k, pc) ^ ghr) : pidx(k, pc);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NK; k++) begin
            m_ghr[k] = 0;
            for (int i = 0; i < 256; i++) begin
                m_ctr[k][i] = (1 << (C_CTR[k] - 1)) - 1;
                m_v[k][i]   = 1'b0;
                m_tag[k][i] = 0;
                m_tgt[k][i] = 32'h0;
            end
        end
    endtask

    task automatic model_pred(input int k, input logic [31:0] pc,
                              output logic p, output logic [31:0] t);
        int  i;
        bit  hit;
        i   = pidx(k, pc);
        hit = m_v[k][i] && (m_tag[k][i] == ptag(k, pc));
        p   = hit && (m_ctr[k][cidx(k, pc, m_ghr[k])] >= (1 << (C_CTR[k] - 1)));
        t   = hit ? m_tgt[k][i] : 32'h0;
    endtask

    task automatic model_train();
        int ci, bi, c;
        bit hit;
        if (!br || stall) return;
        for (int k = 0; k < NK; k++) begin
            ci  = cidx(k, pce, m_ghr[k]);
            bi  = pidx(k, pce);
            hit = m_v[k][bi] && (m_tag[k][bi] == ptag(k, pce));
            c   = m_ctr[k][ci];
            c   = taken ? c + 1 : c - 1;
            if (c > (1 << C_CTR[k]) - 1) c = (1 << C_CTR[k]) - 1;
            if (c < 0) c = 0;
            m_ctr[k][ci] = c;
            m_ghr[k] = ((m_ghr[k] << 1) | int'(taken)) & ((1 << C_GHR[k]) - 1);
            if (taken && (!hit || !tm)) begin
                m_v[k][bi]   = 1'b1;
                m_tag[k][bi] = ptag(k, pce);
                m_tgt[k][bi] = tgt;
            end
        end
    endtask

    // Every cycle, away from the active edge, all instances against the model.
    always @(negedge clk) begin
        logic        ep;
        logic [31:0] et;
        for (int k = 0; k < NK; k++) begin
            model_pred(k, pcf, ep, et);
            checks++;
            if (dut_pred[k] !== ep || dut_tgt[k] !== et) begin
                errors++;
                $display("FAIL model k%0d pcf=%h got pred=%0d tgt=%h want pred=%0d tgt=%h",
                         k, pcf, dut_pred[k], dut_tgt[k], ep, et);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_train();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        tick();
        rst = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] target,
                         input logic match);
        pce = pc; taken = t; tgt = target; tm = match; br = 1'b1; stall = 1'b0;
        tick();
        br = 1'b0;
    endtask

    task automatic query(input logic [31:0] pc);
        pcf = pc;
        #1;
    endtask

    function automatic logic [31:0] rnd_pc();
        return 32'h100 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 3)) << 10);
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; taken = 1'b0; tm = 1'b0;
        pcf = 32'h100; pce = 32'h0; tgt = 32'h0;
        model_clear();
        #2;
        chk("reset pred", 32'(dut_pred[0]), 32'h0);
        chk("reset tgt", dut_tgt[0], 32'h0);
        tick();
        rst = 1'b0;

        // Saturation: four taken, then a fifth, then not-taken steps.
        for (int i = 0; i < 4; i++) train(32'h100, 1'b1, 32'h200, 1'b0);
        query(32'h100);
        chk("bim 4T pred", 32'(dut_pred[1]), 32'h1);
        chk("bim 4T tgt", dut_tgt[1], 32'h200);
        chk("gsh 4T pred", 32'(dut_pred[0]), 32'h0);
        chk("gsh 4T tgt", dut_tgt[0], 32'h200);
        train(32'h100, 1'b1, 32'h200, 1'b1);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        query(32'h100);
        chk("bim sat 5T1N pred", 32'(dut_pred[1]), 32'h1);
        chk("ctr3 5T1N pred", 32'(dut_pred[3]), 32'h1);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        query(32'h100);
        chk("bim 5T2N pred", 32'(dut_pred[1]), 32'h0);

        // Alternating outcome on one PC.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            train(32'h100, (i % 2) == 0, 32'h200, 1'b1);
            query(32'h100);
            chk($sformatf("bim alt %0d", i), 32'(dut_pred[1]), 32'((i % 2) == 0));
            if (i >= 3) chk($sformatf("gsh2 alt %0d", i), 32'(dut_pred[2]), 32'((i % 2) == 1));
        end

        // Tag alias at the same index.
        do_reset();
        train(32'h100, 1'b1, 32'h200, 1'b0);
        query(32'h500);
        chk("alias miss pred", 32'(dut_pred[0]), 32'h0);
        chk("alias miss tgt", dut_tgt[0], 32'h0);
        chk("untagged alias tgt", dut_tgt[3], 32'h200);
        chk("untagged alias pred", 32'(dut_pred[3]), 32'h1);
        train(32'h500, 1'b1, 32'h300, 1'b0);
        query(32'h500);
        chk("alias replaced tgt", dut_tgt[0], 32'h300);
        chk("bim alias pred", 32'(dut_pred[1]), 32'h1);
        query(32'h100);
        chk("orig evicted tgt", dut_tgt[0], 32'h0);
        chk("orig evicted pred", 32'(dut_pred[0]), 32'h0);

        // Stalled branch and non-branch must not train.
        pce = 32'h100; taken = 1'b1; tgt = 32'h998; tm = 1'b0; br = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b0; br = 1'b0;
        tick();
        query(32'h100);
        chk("stall no write", dut_tgt[0], 32'h0);
        chk("nonbranch no write", dut_tgt[1], 32'h0);

        // Reset mid-training aborts the pending write.
        query(32'h500);
        pce = 32'h500; taken = 1'b1; tgt = 32'h700; tm = 1'b0; br = 1'b1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("async reset tgt", dut_tgt[0], 32'h0);
        chk("async reset pred", 32'(dut_pred[0]), 32'h0);
        tick();
        rst = 1'b0; br = 1'b0;
        query(32'h500);
        chk("aborted write", dut_tgt[3], 32'h0);

        // Same-cycle read and write of entry 0x40.
        query(32'h100);
        pce = 32'h100; taken = 1'b1; tgt = 32'h200; tm = 1'b0; br = 1'b1; stall = 1'b0;
        #1;
        chk("rw old tgt", dut_tgt[1], 32'h0);
        tick();
        br = 1'b0;
        #1;
        chk("rw new tgt", dut_tgt[1], 32'h200);
        chk("rw new pred", 32'(dut_pred[1]), 32'h1);

        // 3-bit counter: reset value 3, floor at 0.
        do_reset();
        train(32'h100, 1'b1, 32'h200, 1'b1);
        query(32'h100);
        chk("ctr3 init+1 pred", 32'(dut_pred[3]), 32'h1);
        do_reset();
        for (int i = 0; i < 8; i++) train(32'h100, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) train(32'h100, 1'b1, 32'h200, 1'b1);
        query(32'h100);
        chk("ctr3 floor+3 pred", 32'(dut_pred[3]), 32'h0);
        train(32'h100, 1'b1, 32'h200, 1'b1);
        query(32'h100);
        chk("ctr3 floor+4 pred", 32'(dut_pred[3]), 32'h1);

        // Randomised traffic over a small aliasing PC pool.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            pcf   = rnd_pc();
            pce   = rnd_pc();
            br    = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            taken = 1'($urandom_range(0, 1));
            tm    = 1'($urandom_range(0, 1));
            tgt   = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        br = 1'b0;
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
